// File: rtl/ex_div_pkg.sv
// Shared types and constants for the EX-stage divider (package project_types).
// Optional feature macro used by ex_div: DIV_SIGNED_EN.
package project_types;

  localparam logic RST_ENABLE       = 1'b1;
  localparam logic DIV_RESULT_READY = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START        = 1'b1;
  localparam logic DIV_STOP         = 1'b0;

  localparam logic [5:0] DIV_LAST_STEP = 6'd31;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ZERO = 2'd1,
    DIV_ON   = 2'd2,
    DIV_END  = 2'd3
  } div_state_e;

  // Two's-complement negation of a 32-bit word.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

endpackage

// File: rtl/ex_div_if.sv
// Request/result bundle between the EX stage (master) and the divider (slave).
interface ex_div_if;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/ex_div.sv
// Multi-cycle restoring divider for the EX stage: 32 steps, result {rem, quot}.
// Define DIV_SIGNED_EN to honour signed_div_i (DIV); otherwise every divide is DIVU.
module ex_div
  import project_types::*;
(
  input  logic      clk,
  input  logic      rst,
  ex_div_if.slave   div_if
);

  div_state_e  state_q;
  logic [5:0]  cnt_q;
  logic [64:0] work_q;
  logic [31:0] divisor_q;
  logic [63:0] result_q;
  logic        ready_q;

  logic [33:0] diff_s;
  logic [64:0] work_d;
  logic [31:0] op1_mag_s;
  logic [31:0] op2_mag_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic        stall_s;

`ifdef DIV_SIGNED_EN
  logic neg_quot_q;
  logic neg_rem_q;
  logic op1_neg_s;
  logic op2_neg_s;
`endif

  // One restoring step; bit 64 is kept in the compare so divisors near 2^32 work.
  always_comb begin
    diff_s = {1'b0, work_q[64:32]} - {2'b00, divisor_q};
    if (diff_s[33]) begin
      work_d = {work_q[63:0], 1'b0};
    end else begin
      work_d = {diff_s[31:0], work_q[31:0], 1'b1};
    end
  end

  // Operand magnitudes on entry and sign fix-up of the final step's result.
  always_comb begin
`ifdef DIV_SIGNED_EN
    op1_neg_s = div_if.signed_div_i & div_if.opdata1_i[31];
    op2_neg_s = div_if.signed_div_i & div_if.opdata2_i[31];
    op1_mag_s = op1_neg_s ? neg32(div_if.opdata1_i) : div_if.opdata1_i;
    op2_mag_s = op2_neg_s ? neg32(div_if.opdata2_i) : div_if.opdata2_i;
    quot_s    = neg_quot_q ? neg32(work_d[31:0]) : work_d[31:0];
    rem_s     = neg_rem_q ? neg32(work_d[64:33]) : work_d[64:33];
`else
    op1_mag_s = div_if.opdata1_i;
    op2_mag_s = div_if.opdata2_i;
    quot_s    = work_d[31:0];
    rem_s     = work_d[64:33];
`endif
  end

  // Stall request: the pipeline must hold EX while a divide is pending.
  always_comb begin
    stall_s = 1'b0;
    if (rst == RST_ENABLE || div_if.annul_i) begin
      stall_s = 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: stall_s = div_if.start_i;
        DIV_ZERO: stall_s = 1'b1;
        DIV_ON:   stall_s = 1'b1;
        DIV_END:  stall_s = 1'b0;
        default:  stall_s = 1'b0;
      endcase
    end
  end

  // Divider FSM, working register and registered result/ready.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= 6'd0;
      work_q    <= 65'd0;
      divisor_q <= 32'd0;
      result_q  <= 64'd0;
      ready_q   <= DIV_RESULT_NOT_READY;
`ifdef DIV_SIGNED_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (div_if.start_i == DIV_START && !div_if.annul_i) begin
            if (div_if.opdata2_i == 32'd0) begin
              state_q <= DIV_ZERO;
            end else begin
              state_q   <= DIV_ON;
              cnt_q     <= 6'd0;
              work_q    <= {32'd0, op1_mag_s, 1'b0};
              divisor_q <= op2_mag_s;
`ifdef DIV_SIGNED_EN
              neg_quot_q <= op1_neg_s ^ op2_neg_s;
              neg_rem_q  <= op1_neg_s;
`endif
            end
          end else begin
            state_q <= DIV_IDLE;
          end
        end
        DIV_ZERO: begin
          if (div_if.annul_i) begin
            state_q <= DIV_IDLE;
          end else begin
            state_q  <= DIV_END;
            result_q <= 64'd0;
            ready_q  <= DIV_RESULT_READY;
          end
        end
        DIV_ON: begin
          if (div_if.annul_i) begin
            state_q <= DIV_IDLE;
          end else begin
            work_q <= work_d;
            cnt_q  <= cnt_q + 6'd1;
            if (cnt_q == DIV_LAST_STEP) begin
              state_q  <= DIV_END;
              result_q <= {rem_s, quot_s};
              ready_q  <= DIV_RESULT_READY;
            end else begin
              state_q <= DIV_ON;
            end
          end
        end
        DIV_END: begin
          if (div_if.start_i == DIV_STOP) begin
            state_q  <= DIV_IDLE;
            result_q <= 64'd0;
            ready_q  <= DIV_RESULT_NOT_READY;
          end else begin
            state_q <= DIV_END;
          end
        end
        default: begin
          state_q <= DIV_IDLE;
        end
      endcase
    end
  end

  assign div_if.result_o   = result_q;
  assign div_if.ready_o    = ready_q;
  assign div_if.stallreq_o = stall_s;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed scenarios plus randomized divides
// checked against an arithmetic reference model. Honours DIV_SIGNED_EN.
module tb_ex_div;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ex_div_if bus ();

  ex_div dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] STALL_LONG = 64'h0000_0003_FFFF_FFFE;
  localparam logic [63:0] STALL_ZERO = 64'h0000_0000_0000_0006;

  // Reference: magnitudes, integer divide, then sign rules; divisor 0 gives 0.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sg_in);
    logic sg;
    longint unsigned ma, mb, q, r;
    logic neg_a, neg_b;
`ifdef DIV_SIGNED_EN
    sg = sg_in;
`else
    sg = 1'b0 & sg_in;
`endif
    if (b == 32'd0) return 64'd0;
    neg_a = sg && a[31];
    neg_b = sg && b[31];
    ma = neg_a ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
    mb = neg_b ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
    q = ma / mb;
    r = ma % mb;
    if (neg_a ^ neg_b) q = (64'h1_0000_0000 - q) & 64'hFFFF_FFFF;
    if (neg_a) r = (64'h1_0000_0000 - r) & 64'hFFFF_FFFF;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         output int rdy_cyc, output logic [63:0] svec, output logic [63:0] res);
    rdy_cyc = -1;
    svec = 64'd0;
    res = 64'd0;
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.annul_i = 1'b0; bus.signed_div_i = sg;
    bus.opdata1_i = a; bus.opdata2_i = b;
    for (int c = 1; c <= 50; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
        bus.opdata1_i = $urandom; bus.opdata2_i = $urandom;
        bus.signed_div_i = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      svec[c] = bus.stallreq_o;
      if (bus.ready_o === 1'b1) begin
        rdy_cyc = c;
        res = bus.result_o;
        break;
      end
    end
  endtask

  task automatic finish_div(output logic rdy_drop);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(negedge clk);
    rdy_drop = bus.ready_o;
  endtask

  task automatic test_reset();
    bus.start_i = 1'b1; bus.annul_i = 1'b0; bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd9; bus.opdata2_i = 32'd3;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.stallreq_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", bus.stallreq_o); end
    n_cmp++; if (bus.ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", bus.ready_o); end
    n_cmp++; if (bus.result_o !== 64'd0) begin n_bad++; $display("FAIL reset_result: got %h expected 0", bus.result_o); end
    @(posedge clk); #1;
    rst = 1'b0; bus.start_i = 1'b0;
  endtask

  task automatic test_divu_basic();
    int rc; logic [63:0] sv, res; logic rd;
    run_div(32'd100, 32'd7, 1'b0, rc, sv, res);
    n_cmp++; if (rc != 34) begin n_bad++; $display("FAIL divu_latency: got %0d expected 34", rc); end
    n_cmp++; if (sv !== STALL_LONG) begin n_bad++; $display("FAIL divu_stall: got %h expected %h", sv, STALL_LONG); end
    n_cmp++; if (res !== 64'h00000002_0000000E) begin n_bad++; $display("FAIL divu_result: got %h expected 000000020000000e", res); end
    finish_div(rd);
    n_cmp++; if (rd !== 1'b1) begin n_bad++; $display("FAIL divu_ready_on_drop: got %b expected 1", rd); end
  endtask

  task automatic test_signed();
    int rc; logic [63:0] sv, res, exp; logic rd;
`ifdef DIV_SIGNED_EN
    exp = 64'hFFFFFFFF_FFFFFFFD;
`else
    exp = 64'h00000001_7FFFFFFC;
`endif
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, rc, sv, res);
    n_cmp++; if (res !== exp) begin n_bad++; $display("FAIL div_neg7_by_2: got %h expected %h", res, exp); end
    n_cmp++; if (rc != 34) begin n_bad++; $display("FAIL div_signed_latency: got %0d expected 34", rc); end
    finish_div(rd);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, rc, sv, res);
    n_cmp++; if (res !== 64'h00000001_7FFFFFFC) begin n_bad++; $display("FAIL divu_neg7_by_2: got %h expected 000000017ffffffc", res); end
    finish_div(rd);
  endtask

  task automatic test_div_zero();
    int rc; logic [63:0] sv, res; logic rd;
    run_div(32'h1234_5678, 32'd0, 1'b0, rc, sv, res);
    n_cmp++; if (rc != 3) begin n_bad++; $display("FAIL zero_latency: got %0d expected 3", rc); end
    n_cmp++; if (sv !== STALL_ZERO) begin n_bad++; $display("FAIL zero_stall: got %h expected %h", sv, STALL_ZERO); end
    n_cmp++; if (res !== 64'd0) begin n_bad++; $display("FAIL zero_result: got %h expected 0", res); end
    finish_div(rd);
  endtask

  task automatic test_annul();
    int seen;
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.annul_i = 1'b0; bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c == 10) bus.annul_i = 1'b1;
      @(negedge clk);
      if (c == 10) begin
        n_cmp++; if (bus.stallreq_o !== 1'b0) begin n_bad++; $display("FAIL annul_stall_c10: got %b expected 0", bus.stallreq_o); end
      end else if (c == 5) begin
        n_cmp++; if (bus.stallreq_o !== 1'b1) begin n_bad++; $display("FAIL annul_stall_c5: got %b expected 1", bus.stallreq_o); end
      end
    end
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.annul_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ready_o !== 1'b0 || bus.stallreq_o !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL annul_idle: got %0d active cycles expected 0", seen); end
    // annul in IDLE blocks the start
    bus.start_i = 1'b1; bus.annul_i = 1'b1; bus.opdata2_i = 32'd5;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.stallreq_o !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    bus.start_i = 1'b0; bus.annul_i = 1'b0;
    repeat (36) begin @(negedge clk); if (bus.ready_o !== 1'b0) seen++; end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL annul_blocks_start: got %0d active cycles expected 0", seen); end
    // annul while in DIV_ZERO
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.opdata2_i = 32'd0;
    @(posedge clk); #1;
    bus.annul_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.annul_i = 1'b0;
    seen = 0;
    repeat (3) begin @(negedge clk); if (bus.ready_o !== 1'b0) seen++; end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL annul_zero: got %0d ready cycles expected 0", seen); end
  endtask

  task automatic test_reset_mid();
    int rc; logic [63:0] sv, res; logic rd;
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.annul_i = 1'b0; bus.opdata1_i = 32'd77777; bus.opdata2_i = 32'd13;
    for (int c = 2; c <= 20; c++) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.stallreq_o !== 1'b0) begin n_bad++; $display("FAIL midrst_stall: got %b expected 0", bus.stallreq_o); end
    @(posedge clk); #1;
    rst = 1'b0; bus.start_i = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bus.ready_o, bus.stallreq_o, bus.result_o} !== 66'd0) begin
      n_bad++; $display("FAIL midrst_outputs: got ready=%b stall=%b result=%h expected all 0", bus.ready_o, bus.stallreq_o, bus.result_o);
    end
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, rc, sv, res);
    n_cmp++; if (res !== 64'h00000000_FFFFFFFF) begin n_bad++; $display("FAIL midrst_next_div: got %h expected 00000000ffffffff", res); end
    n_cmp++; if (rc != 34) begin n_bad++; $display("FAIL midrst_latency: got %0d expected 34", rc); end
    finish_div(rd);
  endtask

  task automatic test_end_hold();
    int rc, bad; logic [63:0] sv, res; logic rd;
    run_div(32'd100, 32'd7, 1'b0, rc, sv, res);
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h00000002_0000000E) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL end_hold: got %0d unstable cycles expected 0", bad); end
    finish_div(rd);
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      n_bad++; $display("FAIL end_drop: got ready=%b result=%h expected 0/0", bus.ready_o, bus.result_o);
    end
  endtask

  task automatic test_back_to_back();
    int rc; logic [63:0] sv, res, exp; logic rd;
    logic [31:0] av [3];
    logic [31:0] bv [3];
    av[0] = 32'hFFFF_FFFF; bv[0] = 32'h10;
    av[1] = 32'd5;         bv[1] = 32'd0;
    av[2] = 32'd123456;    bv[2] = 32'd789;
    for (int i = 0; i < 3; i++) begin
      exp = model(av[i], bv[i], 1'b0);
      run_div(av[i], bv[i], 1'b0, rc, sv, res);
      n_cmp++; if (res !== exp || rc != ((bv[i] == 32'd0) ? 3 : 34)) begin
        n_bad++; $display("FAIL b2b_%0d: got %h at cycle %0d expected %h", i, res, rc, exp);
      end
      finish_div(rd);
    end
  endtask

  task automatic test_random();
    int rc, sel; logic [63:0] sv, res, exp; logic rd, sg;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      a = (i % 7 == 3) ? 32'h8000_0000 : $urandom;
      sg = 1'($urandom_range(0, 1));
      exp = model(a, b, sg);
      run_div(a, b, sg, rc, sv, res);
      n_cmp++; if (res !== exp) begin n_bad++; $display("FAIL rand_result_%0d: a=%h b=%h s=%b got %h expected %h", i, a, b, sg, res, exp); end
      n_cmp++; if (rc != ((b == 32'd0) ? 3 : 34)) begin n_bad++; $display("FAIL rand_latency_%0d: got %0d expected %0d", i, rc, (b == 32'd0) ? 3 : 34); end
      finish_div(rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_annul();
    test_reset_mid();
    test_end_hold();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
